// File: rtl/bitserial_add_arbiter.sv
// Two-requester bit-serial adder: one shared full-adder cell, round-robin grant, LSB first.
// Optional signed-overflow output enabled by defining BITSERIAL_ADD_ARBITER_OVF_EN.
module bitserial_add_arbiter #(
    parameter int WIDTH = 32
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic [1:0]         req_valid_i,
    output logic [1:0]         req_ready_o,
    input  logic [2*WIDTH-1:0] req_a_i,
    input  logic [2*WIDTH-1:0] req_b_i,
    input  logic [1:0]         req_cin_i,
    output logic               rsp_valid_o,
    input  logic               rsp_ready_i,
    output logic               rsp_id_o,
    output logic [WIDTH-1:0]   rsp_sum_o,
    output logic               rsp_cout_o,
    output logic               rsp_ovf_o
);

    localparam int CNT_W = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state_r;
    logic [CNT_W-1:0]   cnt_r;
    logic               carry_r;
    logic [WIDTH-1:0]   a_r;
    logic [WIDTH-1:0]   b_r;
    logic [WIDTH-1:0]   sum_r;
    logic               last_grant_r;
    logic               id_r;
    logic               valid_r;

    logic               grant_s;
    logic               accept_s;
    logic               sum_bit_s;
    logic               cout_s;
    logic               last_bit_s;

    function automatic logic [1:0] full_add(input logic a, input logic b, input logic c);
        return {(a & b) | (a & c) | (b & c), a ^ b ^ c};
    endfunction

    // Round-robin selection: on contention the requester not served last wins
    always_comb begin
        grant_s = 1'b0;
        if (req_valid_i == 2'b11) begin
            grant_s = ~last_grant_r;
        end else if (req_valid_i[0]) begin
            grant_s = 1'b0;
        end else begin
            grant_s = 1'b1;
        end
    end

    assign accept_s   = (state_r == IDLE) && (|req_valid_i);
    assign {cout_s, sum_bit_s} = full_add(a_r[0], b_r[0], carry_r);
    assign last_bit_s = (cnt_r == CNT_W'(WIDTH - 1));

    // Accept strobe; gated by reset so it reads 0 while rst_ni is low
    always_comb begin
        req_ready_o = 2'b00;
        if (rst_ni && accept_s) begin
            req_ready_o = grant_s ? 2'b10 : 2'b01;
        end else begin
            req_ready_o = 2'b00;
        end
    end

    // Control FSM and serial datapath; operands shift right so bit 0 always feeds the adder
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_r      <= IDLE;
            cnt_r        <= '0;
            carry_r      <= 1'b0;
            a_r          <= '0;
            b_r          <= '0;
            sum_r        <= '0;
            last_grant_r <= 1'b1;
            id_r         <= 1'b0;
            valid_r      <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (accept_s) begin
                        a_r          <= grant_s ? req_a_i[2*WIDTH-1:WIDTH] : req_a_i[WIDTH-1:0];
                        b_r          <= grant_s ? req_b_i[2*WIDTH-1:WIDTH] : req_b_i[WIDTH-1:0];
                        carry_r      <= req_cin_i[grant_s];
                        last_grant_r <= grant_s;
                        id_r         <= grant_s;
                        cnt_r        <= '0;
                        state_r      <= RUN;
                    end else begin
                        state_r      <= IDLE;
                    end
                end
                RUN: begin
                    sum_r   <= {sum_bit_s, sum_r[WIDTH-1:1]};
                    carry_r <= cout_s;
                    a_r     <= a_r >> 1;
                    b_r     <= b_r >> 1;
                    cnt_r   <= cnt_r + CNT_W'(1);
                    if (last_bit_s) begin
                        state_r <= DONE;
                        valid_r <= 1'b1;
                    end else begin
                        state_r <= RUN;
                    end
                end
                DONE: begin
                    if (rsp_ready_i) begin
                        valid_r <= 1'b0;
                        state_r <= IDLE;
                    end else begin
                        state_r <= DONE;
                    end
                end
                default: begin
                    state_r <= IDLE;
                    valid_r <= 1'b0;
                end
            endcase
        end
    end

`ifdef BITSERIAL_ADD_ARBITER_OVF_EN
    logic ovf_r;

    // Overflow = carry into MSB xor carry out, both visible on the final RUN cycle
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ovf_r <= 1'b0;
        end else if ((state_r == RUN) && last_bit_s) begin
            ovf_r <= carry_r ^ cout_s;
        end else begin
            ovf_r <= ovf_r;
        end
    end

    assign rsp_ovf_o = ovf_r;
`else
    assign rsp_ovf_o = 1'b0;
`endif

    assign rsp_valid_o = valid_r;
    assign rsp_id_o    = id_r;
    assign rsp_sum_o   = sum_r;
    assign rsp_cout_o  = carry_r;

endmodule

// File: tb/tb_bitserial_add_arbiter.sv
// Self-checking bench for bitserial_add_arbiter (WIDTH=8): vector table plus scoreboard.
module tb_bitserial_add_arbiter;

    localparam int W = 8;
`ifdef BITSERIAL_ADD_ARBITER_OVF_EN
    localparam logic OVF_ON = 1'b1;
`else
    localparam logic OVF_ON = 1'b0;
`endif

    logic           clk_i = 1'b0;
    logic           rst_ni = 1'b0;
    logic [1:0]     req_valid_i;
    logic [1:0]     req_ready_o;
    logic [2*W-1:0] req_a_i;
    logic [2*W-1:0] req_b_i;
    logic [1:0]     req_cin_i;
    logic           rsp_valid_o;
    logic           rsp_ready_i;
    logic           rsp_id_o;
    logic [W-1:0]   rsp_sum_o;
    logic           rsp_cout_o;
    logic           rsp_ovf_o;

    bitserial_add_arbiter #(.WIDTH(W)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
        .req_a_i(req_a_i), .req_b_i(req_b_i), .req_cin_i(req_cin_i),
        .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i), .rsp_id_o(rsp_id_o),
        .rsp_sum_o(rsp_sum_o), .rsp_cout_o(rsp_cout_o), .rsp_ovf_o(rsp_ovf_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        int         r;
        logic [7:0] a;
        logic [7:0] b;
        logic       cin;
        logic [7:0] sum;
        logic       cout;
        logic       ovf;
    } vec_t;

    typedef struct {
        logic       id;
        logic [7:0] sum;
        logic       cout;
        logic       ovf;
    } exp_t;

    exp_t       sb[$];
    exp_t       pend[2];
    logic       acc_flag[2];
    int         grant_log[$];
    int         acc_log[$];
    int         n_checks = 0;
    int         n_fail = 0;
    int         cyc = 0;
    int         acc_cyc = -100;
    int         hs_cyc = -100;
    bit         chk_after_hs = 1'b0;
    logic       prev_hold = 1'b0;
    logic [7:0] held_sum;
    logic       held_cout, held_id, held_ovf;
    vec_t       tbl[7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    // Monitor: push on accept, pop and compare on response handshake
    always @(negedge clk_i) begin
        int   g;
        exp_t e;
        #2;
        cyc++;
        if (!rst_ni) begin
            prev_hold = 1'b0;
        end else begin
            if (req_ready_o != 2'b00) begin
                g = req_ready_o[1] ? 1 : 0;
                check("ready_onehot", 32'($countones(req_ready_o)), 32'd1);
                if (chk_after_hs) begin
                    check("accept_after_handshake", 32'(cyc - hs_cyc), 32'd1);
                    chk_after_hs = 1'b0;
                end
                sb.push_back(pend[g]);
                acc_flag[g] = 1'b1;
                grant_log.push_back(g);
                acc_log.push_back(cyc);
                acc_cyc = cyc;
            end
            if (rsp_valid_o) begin
                check("ready_low_in_done", 32'(req_ready_o), 32'd0);
                if (prev_hold) begin
                    check("hold_sum", 32'(rsp_sum_o), 32'(held_sum));
                    check("hold_cout", 32'(rsp_cout_o), 32'(held_cout));
                    check("hold_id", 32'(rsp_id_o), 32'(held_id));
                    check("hold_ovf", 32'(rsp_ovf_o), 32'(held_ovf));
                end else begin
                    check("latency", 32'(cyc - acc_cyc), 32'(W + 1));
                end
                if (sb.size() == 0) begin
                    check("unexpected_rsp", 32'd1, 32'd0);
                end else if (rsp_ready_i) begin
                    e = sb.pop_front();
                    check("sum", 32'(rsp_sum_o), 32'(e.sum));
                    check("cout", 32'(rsp_cout_o), 32'(e.cout));
                    check("id", 32'(rsp_id_o), 32'(e.id));
                    check("ovf", 32'(rsp_ovf_o), 32'(e.ovf));
                    hs_cyc = cyc;
                end
                prev_hold = !rsp_ready_i;
                held_sum  = rsp_sum_o;
                held_cout = rsp_cout_o;
                held_id   = rsp_id_o;
                held_ovf  = rsp_ovf_o;
            end else begin
                prev_hold = 1'b0;
            end
        end
    end

    task automatic issue(input int r, input logic [7:0] a, input logic [7:0] b, input logic cin,
                         input logic [7:0] s, input logic co, input logic ov);
        pend[r].id   = r[0];
        pend[r].sum  = s;
        pend[r].cout = co;
        pend[r].ovf  = ov & OVF_ON;
        acc_flag[r]  = 1'b0;
        req_a_i[r*W +: W] = a;
        req_b_i[r*W +: W] = b;
        req_cin_i[r]      = cin;
        req_valid_i[r]    = 1'b1;
    endtask

    task automatic wait_accept(input int r);
        int k;
        for (k = 0; k < 200; k++) begin
            #3;
            if (acc_flag[r]) break;
            @(negedge clk_i);
        end
        if (k == 200) check("accept_timeout", 32'd0, 32'd1);
        @(negedge clk_i);
        req_valid_i[r] = 1'b0;
    endtask

    task automatic wait_drain();
        int k;
        for (k = 0; k < 300; k++) begin
            @(negedge clk_i);
            #3;
            if (sb.size() == 0) break;
        end
        if (k == 300) check("drain_timeout", 32'(sb.size()), 32'd0);
    endtask

    initial begin
        int k;
        req_valid_i = 2'b11;
        req_a_i     = '0;
        req_b_i     = '0;
        req_cin_i   = 2'b00;
        rsp_ready_i = 1'b1;
        rst_ni      = 1'b0;

        tbl[0] = '{0, 8'h5A, 8'h33, 1'b0, 8'h8D, 1'b0, 1'b1};
        tbl[1] = '{1, 8'hFF, 8'h01, 1'b1, 8'h01, 1'b1, 1'b0};
        tbl[2] = '{0, 8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1};
        tbl[3] = '{1, 8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1};
        tbl[4] = '{0, 8'h00, 8'h00, 1'b1, 8'h01, 1'b0, 1'b0};
        tbl[5] = '{1, 8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0};
        tbl[6] = '{0, 8'hA5, 8'h5A, 1'b0, 8'hFF, 1'b0, 1'b0};

        // Reset state, with requests pending to prove ready is gated
        repeat (3) @(negedge clk_i);
        #1;
        check("rst_valid", 32'(rsp_valid_o), 32'd0);
        check("rst_sum", 32'(rsp_sum_o), 32'd0);
        check("rst_cout", 32'(rsp_cout_o), 32'd0);
        check("rst_ovf", 32'(rsp_ovf_o), 32'd0);
        check("rst_id", 32'(rsp_id_o), 32'd0);
        check("rst_ready", 32'(req_ready_o), 32'd0);
        req_valid_i = 2'b00;
        @(negedge clk_i);
        rst_ni = 1'b1;

        for (int i = 0; i < 7; i++) begin
            @(negedge clk_i);
            issue(tbl[i].r, tbl[i].a, tbl[i].b, tbl[i].cin, tbl[i].sum, tbl[i].cout, tbl[i].ovf);
            wait_accept(tbl[i].r);
            wait_drain();
        end

        // Contention straight after reset: 0,1,0,1 at one result per W+2 cycles
        @(negedge clk_i);
        rst_ni = 1'b0;
        @(negedge clk_i);
        rst_ni = 1'b1;
        grant_log.delete();
        acc_log.delete();
        @(negedge clk_i);
        issue(0, 8'h12, 8'h34, 1'b0, 8'h46, 1'b0, 1'b0);
        issue(1, 8'hF0, 8'h20, 1'b1, 8'h11, 1'b1, 1'b0);
        for (k = 0; k < 100; k++) begin
            #3;
            if (grant_log.size() >= 4) break;
            @(negedge clk_i);
        end
        if (k == 100) check("contention_timeout", 32'(grant_log.size()), 32'd4);
        @(negedge clk_i);
        req_valid_i = 2'b00;
        wait_drain();
        if (grant_log.size() >= 4) begin
            for (int i = 0; i < 4; i++) check("grant_order", 32'(grant_log[i]), 32'(i % 2));
            for (int i = 0; i < 3; i++) check("throughput", 32'(acc_log[i+1] - acc_log[i]), 32'(W + 2));
        end

        // Back-pressure in DONE for 5 cycles with requester 1 waiting
        @(negedge clk_i);
        rsp_ready_i = 1'b0;
        issue(0, 8'h5A, 8'h33, 1'b0, 8'h8D, 1'b0, 1'b1);
        wait_accept(0);
        issue(1, 8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1);
        for (k = 0; k < 50; k++) begin
            @(negedge clk_i);
            #3;
            if (rsp_valid_o) break;
        end
        if (k == 50) check("done_timeout", 32'd0, 32'd1);
        repeat (5) @(negedge clk_i);
        rsp_ready_i  = 1'b1;
        chk_after_hs = 1'b1;
        wait_accept(1);
        wait_drain();

        // Reset during RUN discards the operation
        @(negedge clk_i);
        issue(0, 8'h11, 8'h22, 1'b0, 8'h33, 1'b0, 1'b0);
        @(negedge clk_i);
        req_valid_i = 2'b00;
        check("midrun_accepted", 32'(acc_flag[0]), 32'd1);
        repeat (4) @(negedge clk_i);
        #1;
        rst_ni = 1'b0;
        sb.delete();
        #1;
        check("midrun_rst_valid", 32'(rsp_valid_o), 32'd0);
        check("midrun_rst_sum", 32'(rsp_sum_o), 32'd0);
        repeat (2) @(negedge clk_i);
        rst_ni = 1'b1;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk_i);
            #3;
            check("discarded_no_rsp", 32'(rsp_valid_o), 32'd0);
        end
        @(negedge clk_i);
        issue(0, 8'h10, 8'h20, 1'b0, 8'h30, 1'b0, 1'b0);
        wait_accept(0);
        wait_drain();

        @(negedge clk_i);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/bitserial_add_arbiter.md
BITSERIAL_ADD_ARBITER -- requirements
Module: bitserial_add_arbiter

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, giving the operand width in bits (legal range 2..64).
REQ-002 The block SHALL have port clk_i, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst_ni, input, 1 bit: asynchronous active-low reset.
REQ-004 The block SHALL have port req_valid_i, input, 2 bits: per-requester operand-valid signal.
REQ-005 The block SHALL have port req_ready_o, output, 2 bits: per-requester accept strobe.
REQ-006 The block SHALL have port req_a_i, input, 2*WIDTH bits: operand A (requester r at bits [r*WIDTH +: WIDTH]).
REQ-007 The block SHALL have port req_b_i, input, 2*WIDTH bits: operand B, same packing as req_a_i.
REQ-008 The block SHALL have port req_cin_i, input, 2 bits: per-requester carry-in.
REQ-009 The block SHALL have port rsp_valid_o, output, 1 bit: result valid.
REQ-010 The block SHALL have port rsp_ready_i, input, 1 bit: result consumer ready.
REQ-011 The block SHALL have port rsp_id_o, output, 1 bit: index of the requester that owns the result.
REQ-012 The block SHALL have port rsp_sum_o, output, WIDTH bits: the sum.
REQ-013 The block SHALL have port rsp_cout_o, output, 1 bit: the carry-out.
REQ-014 The block SHALL have port rsp_ovf_o, output, 1 bit: the signed overflow flag (see Configuration).

Function
REQ-015 The block SHALL share one 1-bit full-adder cell between both requesters and compute one sum bit per cycle, LSB first.
REQ-016 The block SHALL implement a three-state FSM: IDLE, RUN, DONE.
REQ-017 In IDLE with any req_valid_i bit set, the block SHALL grant exactly one requester and go to RUN on the next edge.
- req_ready_o[g] is high combinationally in that IDLE cycle only.
- Operands and carry-in of the granted requester are latched.
- The bit counter is cleared to 0.
REQ-018 Arbitration SHALL be round-robin: if both requesters are valid, grant the one not granted last; if only one is valid, grant it.
REQ-019 The last-grant register SHALL reset to 1, so requester 0 wins the first contention.
REQ-020 In RUN, each cycle SHALL do the following:
- Compute sum bit cnt from A[cnt], B[cnt] and the carry register.
- Write that bit into the sum shift register and update the carry register.
- Increment cnt.
- On the cycle with cnt==WIDTH-1, go to DONE.
REQ-021 req_ready_o SHALL be 0 in RUN and DONE; req_valid_i SHALL be ignored outside IDLE.
REQ-022 In DONE, rsp_valid_o SHALL be 1 and rsp_sum_o, rsp_cout_o, rsp_id_o and rsp_ovf_o SHALL hold stable until rsp_ready_i is sampled 1; the block then returns to IDLE.
REQ-023 Latency from the accept cycle T to the first rsp_valid_o cycle SHALL be exactly WIDTH+1 cycles.
REQ-024 Back-to-back throughput SHALL be one result per WIDTH+2 cycles when rsp_ready_i is held at 1.
REQ-025 Arithmetic SHALL be modulo 2^WIDTH, with rsp_cout_o equal to bit WIDTH of A+B+cin.
REQ-026 The counter SHALL be clog2(WIDTH)+1 bits wide and SHALL never wrap.
REQ-027 Deasserting req_valid_i while granted SHALL have no effect on an operation already accepted.

Reset
REQ-028 While rst_ni is 0, the block SHALL hold the following, asynchronously and regardless of clk_i:
- FSM=IDLE, cnt=0, carry=0, sum register=0, last-grant=1.
- rsp_valid_o=0, rsp_sum_o=0, rsp_cout_o=0, rsp_ovf_o=0, rsp_id_o=0, req_ready_o=0.
REQ-029 Reset asserted in RUN or DONE SHALL discard the operation with no response.
REQ-030 After rst_ni rises, the first grant SHALL occur at the first clock edge with a valid request.

Configuration
REQ-031 With macro BITSERIAL_ADD_ARBITER_OVF_EN defined, the block SHALL compute rsp_ovf_o as carry-into-MSB XOR carry-out, captured during the final RUN cycle.
REQ-032 Without BITSERIAL_ADD_ARBITER_OVF_EN, the block SHALL tie rsp_ovf_o to constant 0 and SHALL contain no overflow register.

Verification
REQ-033 WIDTH=8, req0 only, A=0x5A, B=0x33, cin=0 -> rsp_sum_o=0x8D, cout=0, id=0, ovf=1 (macro on) / 0 (macro off); rsp_valid_o rises exactly 9 cycles after accept.
REQ-034 WIDTH=8, req1 only, A=0xFF, B=0x01, cin=1 -> rsp_sum_o=0x01, cout=1, id=1, ovf=0.
REQ-035 WIDTH=8, both requesters valid continuously after reset -> grant order 0,1,0,1 and rsp_id_o sequence 0,1,0,1.
REQ-036 WIDTH=8, hold rsp_ready_i=0 for 5 cycles in DONE -> outputs stable, req_ready_o=0 throughout; accept occurs on the cycle after the handshake completes.
REQ-037 WIDTH=8, assert rst_ni=0 at RUN cycle 4 -> rsp_valid_o never rises for that operation; the next req0 add of 0x10+0x20 returns 0x30.
